// File: rtl/store_buffer_if.sv
// Store-queue bus: MEM-stage store request, data-memory drain port and load-hazard probe.
// Handshake: a transfer happens on a rising clk edge where valid && ready; valid never waits on ready.
interface store_buffer_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            st_valid;
   logic            st_ready;
   logic [AW-1:0]   st_addr;
   logic [DW-1:0]   st_data;
   logic [DW/8-1:0] st_strb;
   logic            mem_valid;
   logic            mem_ready;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_data;
   logic [DW/8-1:0] mem_strb;
   logic [AW-1:0]   ld_addr;
   logic            ld_hit;

   modport slave (
      input  st_valid, st_addr, st_data, st_strb, mem_ready, ld_addr,
      output st_ready, mem_valid, mem_addr, mem_data, mem_strb, ld_hit
   );

   modport master (
      output st_valid, st_addr, st_data, st_strb, mem_ready, ld_addr,
      input  st_ready, mem_valid, mem_addr, mem_data, mem_strb, ld_hit
   );
endinterface

// File: rtl/store_buffer.sv
// In-order store queue between lane masking and data memory, with a same-word
// load-hit flag for the hazard unit. No bypass: a store is drainable one edge after acceptance.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   store_buffer_if.slave              bus,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int SW = DW / 8;

   logic [AW-3:0]    addr_q [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [SW-1:0]    strb_q [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push, pop, hit;
   logic             unused_lsbs;

   assign bus.st_ready  = rst_n && (count_q < CW'(DEPTH));
   assign bus.mem_valid = (count_q != '0);
   assign bus.mem_addr  = {addr_q[rd_ptr_q], 2'b00};
   assign bus.mem_data  = data_q[rd_ptr_q];
   assign bus.mem_strb  = strb_q[rd_ptr_q];
   assign bus.ld_hit    = hit;
   assign count         = count_q;
   assign empty         = (count_q == '0);
   assign unused_lsbs   = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};

   // An all-zero strobe completes the handshake but leaves nothing to write.
   assign push = bus.st_valid && bus.st_ready && (bus.st_strb != '0);
   assign pop  = bus.mem_valid && bus.mem_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      valid_d  = valid_q;
      if (push) begin
         wr_ptr_d          = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
         valid_d[wr_ptr_q] = 1'b1;
      end
      if (pop) begin
         rd_ptr_d          = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
         valid_d[rd_ptr_q] = 1'b0;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Only word-address bits take part; a store landing this cycle is not yet valid.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (addr_q[i] == bus.ld_addr[AW-1:2])) hit = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr_q] <= bus.st_addr[AW-1:2];
         data_q[wr_ptr_q] <= bus.st_data;
         strb_q[wr_ptr_q] <= bus.st_strb;
      end
   end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: per-cycle vector table plus hand-written fill,
// wrap, backpressure and reset sequences; a monitor checks drained entries against exp_q.
module tb_store_buffer;
   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] count;
   logic       empty;

   always #5 clk = ~clk;

   store_buffer_if #(.AW(AW), .DW(DW)) sb_if ();

   store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sb_if.slave),
      .count (count),
      .empty (empty)
   );

   int          total = 0;
   int          bad   = 0;
   logic [67:0] exp_q [$];
   logic [67:0] mon_e;

   typedef struct {
      logic        sv;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        mr;
      logic [31:0] la;
      logic [2:0]  e_cnt;
      logic        e_mv;
      logic [31:0] e_ma;
      logic        e_hit;
      logic        e_rdy;
   } vec_t;

   vec_t vt [13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic mr, input logic [31:0] la);
      sb_if.st_valid  = v;
      sb_if.st_addr   = a;
      sb_if.st_data   = d;
      sb_if.st_strb   = s;
      sb_if.mem_ready = mr;
      sb_if.ld_addr   = la;
   endtask

   task automatic to_check();
      @(negedge clk);
   endtask

   task automatic to_drive();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      sb_if.st_valid  = 1'b0;
      sb_if.mem_ready = 1'b1;
      to_check();
      while (count != 3'd0 && n < 20) begin
         to_drive();
         to_check();
         n++;
      end
      check("drain_empty", 64'(empty), 64'd1);
      check("drain_exp_q", 64'(exp_q.size()), 64'd0);
      to_drive();
   endtask

   // Scoreboard: pops are compared before same-edge pushes since a push is always newer.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (sb_if.mem_valid && sb_if.mem_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL pop_unexpected: got addr %h expected no entry", sb_if.mem_addr);
            end else begin
               mon_e = exp_q.pop_front();
               if ({sb_if.mem_addr, sb_if.mem_data, sb_if.mem_strb} !== mon_e) begin
                  bad++;
                  $display("FAIL pop_order: got %h expected %h",
                           {sb_if.mem_addr, sb_if.mem_data, sb_if.mem_strb}, mon_e);
               end
            end
         end
         if (sb_if.st_valid && sb_if.st_ready && sb_if.st_strb != 4'h0)
            exp_q.push_back({sb_if.st_addr & ~32'h3, sb_if.st_data, sb_if.st_strb});
      end
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      //        sv    addr          data          strb   mr    ld_addr       cnt   mv    mem_addr      hit   rdy
      vt[0]  = '{1'b1, 32'h104, 32'h0000AB00, 4'h2, 1'b1, 32'h000, 3'd0, 1'b0, 32'h000, 1'b0, 1'b1};
      vt[1]  = '{1'b0, 32'h000, 32'h00000000, 4'h0, 1'b1, 32'h104, 3'd1, 1'b1, 32'h104, 1'b1, 1'b1};
      vt[2]  = '{1'b0, 32'h000, 32'h00000000, 4'h0, 1'b1, 32'h104, 3'd0, 1'b0, 32'h000, 1'b0, 1'b1};
      vt[3]  = '{1'b1, 32'h200, 32'h11000000, 4'h8, 1'b0, 32'h202, 3'd0, 1'b0, 32'h000, 1'b0, 1'b1};
      vt[4]  = '{1'b0, 32'h000, 32'h00000000, 4'h0, 1'b0, 32'h202, 3'd1, 1'b1, 32'h200, 1'b1, 1'b1};
      vt[5]  = '{1'b0, 32'h000, 32'h00000000, 4'h0, 1'b0, 32'h204, 3'd1, 1'b1, 32'h200, 1'b0, 1'b1};
      vt[6]  = '{1'b0, 32'h000, 32'h00000000, 4'h0, 1'b1, 32'h203, 3'd1, 1'b1, 32'h200, 1'b1, 1'b1};
      vt[7]  = '{1'b0, 32'h000, 32'h00000000, 4'h0, 1'b1, 32'h202, 3'd0, 1'b0, 32'h000, 1'b0, 1'b1};
      vt[8]  = '{1'b1, 32'h400, 32'h000000FF, 4'h0, 1'b0, 32'h400, 3'd0, 1'b0, 32'h000, 1'b0, 1'b1};
      vt[9]  = '{1'b0, 32'h000, 32'h00000000, 4'h0, 1'b0, 32'h400, 3'd0, 1'b0, 32'h000, 1'b0, 1'b1};
      vt[10] = '{1'b1, 32'h107, 32'h00000055, 4'h1, 1'b0, 32'h000, 3'd0, 1'b0, 32'h000, 1'b0, 1'b1};
      vt[11] = '{1'b0, 32'h000, 32'h00000000, 4'h0, 1'b1, 32'h104, 3'd1, 1'b1, 32'h104, 1'b1, 1'b1};
      vt[12] = '{1'b0, 32'h000, 32'h00000000, 4'h0, 1'b0, 32'h104, 3'd0, 1'b0, 32'h000, 1'b0, 1'b1};

      // Reset state
      rst_n = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
      to_drive();
      to_drive();
      to_check();
      check("rst_st_ready", 64'(sb_if.st_ready), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_mem_valid", 64'(sb_if.mem_valid), 64'd0);
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_ld_hit", 64'(sb_if.ld_hit), 64'd0);
      to_drive();
      rst_n = 1'b1;

      // Vector table
      for (int i = 0; i < 13; i++) begin
         drive(vt[i].sv, vt[i].a, vt[i].d, vt[i].s, vt[i].mr, vt[i].la);
         to_check();
         check($sformatf("vec%0d_st_ready", i), 64'(sb_if.st_ready), 64'(vt[i].e_rdy));
         check($sformatf("vec%0d_count", i), 64'(count), 64'(vt[i].e_cnt));
         check($sformatf("vec%0d_empty", i), 64'(empty), 64'(vt[i].e_cnt == 3'd0));
         check($sformatf("vec%0d_mem_valid", i), 64'(sb_if.mem_valid), 64'(vt[i].e_mv));
         check($sformatf("vec%0d_ld_hit", i), 64'(sb_if.ld_hit), 64'(vt[i].e_hit));
         if (vt[i].e_mv)
            check($sformatf("vec%0d_mem_addr", i), 64'(sb_if.mem_addr), 64'(vt[i].e_ma));
         to_drive();
      end

      // Fill past capacity, then release the memory side
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h500 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, 1'b0, 32'h0);
         to_check();
         check($sformatf("fill%0d_st_ready", i), 64'(sb_if.st_ready), 64'd1);
         check($sformatf("fill%0d_count", i), 64'(count), 64'(i));
         to_drive();
      end
      drive(1'b1, 32'h510, 32'hA4, 4'hF, 1'b0, 32'h0);
      for (int k = 0; k < 2; k++) begin
         to_check();
         check("full_st_ready", 64'(sb_if.st_ready), 64'd0);
         check("full_count", 64'(count), 64'd4);
         to_drive();
      end
      sb_if.mem_ready = 1'b1;
      to_check();
      check("full_pop_no_pass", 64'(sb_if.st_ready), 64'd0);
      check("full_head_addr", 64'(sb_if.mem_addr), 64'h500);
      to_drive();
      to_check();
      check("after_pop_count", 64'(count), 64'd3);
      check("after_pop_st_ready", 64'(sb_if.st_ready), 64'd1);
      to_drive();
      to_check();
      check("fifth_in_count", 64'(count), 64'd3);
      to_drive();
      drain();

      // Steady push+pop at count 2, wrapping both pointers
      drive(1'b1, 32'h600, 32'hC0000000, 4'hF, 1'b0, 32'h0);
      to_drive();
      drive(1'b1, 32'h604, 32'hC0000001, 4'h3, 1'b0, 32'h0);
      to_drive();
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 32'h608 + 32'(4 * k), 32'hC0 + 32'(k), 4'hC, 1'b1, 32'h0);
         to_check();
         check($sformatf("steady%0d_count", k), 64'(count), 64'd2);
         to_drive();
      end
      drain();

      // Backpressure holds the head stable
      drive(1'b1, 32'h300, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
      to_drive();
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
         to_check();
         check("bp_mem_valid", 64'(sb_if.mem_valid), 64'd1);
         check("bp_mem_addr", 64'(sb_if.mem_addr), 64'h300);
         check("bp_mem_data", 64'(sb_if.mem_data), 64'hDEADBEEF);
         check("bp_mem_strb", 64'(sb_if.mem_strb), 64'hF);
         to_drive();
      end
      drain();

      // Reset with three entries pending
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h700 + 32'(4 * i), 32'hE0 + 32'(i), 4'hF, 1'b0, 32'h0);
         to_drive();
      end
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h704);
      to_check();
      check("prerst_count", 64'(count), 64'd3);
      check("prerst_ld_hit", 64'(sb_if.ld_hit), 64'd1);
      to_drive();
      rst_n = 1'b0;
      drive(1'b1, 32'h70C, 32'hE3, 4'hF, 1'b0, 32'h704);
      to_check();
      check("inrst_st_ready", 64'(sb_if.st_ready), 64'd0);
      to_drive();
      rst_n = 1'b1;
      exp_q.delete();
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h704);
      to_check();
      check("postrst_count", 64'(count), 64'd0);
      check("postrst_mem_valid", 64'(sb_if.mem_valid), 64'd0);
      check("postrst_ld_hit", 64'(sb_if.ld_hit), 64'd0);
      check("postrst_empty", 64'(empty), 64'd1);
      for (int k = 0; k < 3; k++) begin
         to_drive();
         to_check();
         check("postrst_no_stale", 64'(sb_if.mem_valid), 64'd0);
      end
      to_drive();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
